// File: rtl/spec_hilo_queue_pkg.sv
// spec_hilo_queue_pkg: shared slot and tag types for the speculative HI/LO queue
package spec_hilo_queue_pkg;
  localparam int HILO_WIDTH = 64;
  localparam int HILO_DEPTH = 4;
  typedef logic [$clog2(HILO_DEPTH)-1:0] hilo_tag_t;
  typedef struct packed {
    logic                  used;
    logic                  written;
    logic [HILO_WIDTH-1:0] data;
  } spec_hilo_entry_t;
endpackage

// File: rtl/spec_hilo_queue_ring_ptr.sv
// ring_ptr: modulo-2^W pointer with synchronous clear and increment
module ring_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;
  always_ff @(posedge clk) ptr_q <= (rst || clr_i) ? '0 : ptr_q + W'(inc_i);
  assign ptr_o = ptr_q;
endmodule

// File: rtl/spec_hilo_queue.sv
// spec_hilo_queue: speculative HI/LO ring of tagged slots, in-order retire into arch.
// SPEC_HILO_FWD_EN exposes the youngest slot on spec_data_o for speculative MFHI/MFLO.
module spec_hilo_queue
  import spec_hilo_queue_pkg::*;
#(
  parameter int               WIDTH       = HILO_WIDTH,
  parameter int               DEPTH       = HILO_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  output logic                     ready_o,
  output logic [$clog2(DEPTH)-1:0] alloc_tag_o,
  input  logic                     wr_valid_i,
  input  logic [$clog2(DEPTH)-1:0] wr_tag_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     commit_i,
  output logic                     commit_stall_o,
  output logic [WIDTH-1:0]         arch_data_o,
  output logic [WIDTH-1:0]         spec_data_o,
  output logic                     spec_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  spec_hilo_entry_t slot_q [DEPTH];
  spec_hilo_entry_t slot_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] arch_q, arch_d, commit_data;
  logic [AW-1:0]    head, tail, young;
  logic             do_alloc, do_commit, bypass, do_write;
  ring_ptr #(.W(AW)) u_head (.clk(clk), .rst(rst), .clr_i(flush_i), .inc_i(do_commit), .ptr_o(head));
  ring_ptr #(.W(AW)) u_tail (.clk(clk), .rst(rst), .clr_i(flush_i), .inc_i(do_alloc), .ptr_o(tail));
  assign ready_o        = count_q != CW'(DEPTH);
  assign alloc_tag_o    = tail;
  assign commit_stall_o = slot_q[head].used & ~slot_q[head].written;
  assign arch_data_o    = arch_q;
  assign young          = tail - AW'(1);
  assign do_alloc       = alloc_i & ready_o & ~flush_i;
  assign do_write       = wr_valid_i & slot_q[wr_tag_i].used & ~flush_i;
  assign bypass         = wr_valid_i & (wr_tag_i == head);
  // A head slot that is already written retires its stored value even if rewritten this cycle
  assign do_commit      = commit_i & slot_q[head].used & (slot_q[head].written | bypass);
  assign commit_data    = slot_q[head].written ? WIDTH'(slot_q[head].data) : wr_data_i;
`ifdef SPEC_HILO_FWD_EN
  assign spec_data_o  = (count_q == '0) ? arch_q : WIDTH'(slot_q[young].data);
  assign spec_valid_o = (count_q == '0) | slot_q[young].written;
`else
  assign spec_data_o  = arch_q;
  assign spec_valid_o = count_q == '0;
`endif
  always_comb begin
    slot_d  = slot_q;
    arch_d  = do_commit ? commit_data : arch_q;
    count_d = flush_i ? '0 : count_q + CW'(do_alloc) - CW'(do_commit);
    if (do_write) begin
      slot_d[wr_tag_i].written = 1'b1;
      slot_d[wr_tag_i].data    = HILO_WIDTH'(wr_data_i);
    end
    if (do_commit) slot_d[head] = '0;
    if (do_alloc) slot_d[tail] = '{used: 1'b1, written: 1'b0, data: '0};
    if (flush_i) slot_d = '{default: '0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '{default: '0};
      count_q <= '0;
      arch_q  <= RESET_VALUE;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      arch_q  <= arch_d;
    end
  end
endmodule

// File: tb/tb_spec_hilo_queue.sv
// tb_spec_hilo_queue: directed scenarios plus random traffic against an in-order queue model
module tb_spec_hilo_queue;
  localparam int D = 4;
`ifdef SPEC_HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, alloc = 0, wr_valid = 0, commit = 0;
  logic [1:0] wr_tag = 0, alloc_tag;
  logic [63:0] wr_data = 0, arch_data, spec_data;
  logic ready, commit_stall, spec_valid;
  int passed = 0, total = 0;
  typedef struct {int tag; bit wr; logic [63:0] d;} ent_t;
  ent_t mq[$];
  int mnext = 0;
  logic [63:0] march = 0;

  spec_hilo_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush), .alloc_i(alloc), .ready_o(ready),
    .alloc_tag_o(alloc_tag), .wr_valid_i(wr_valid), .wr_tag_i(wr_tag), .wr_data_i(wr_data),
    .commit_i(commit), .commit_stall_o(commit_stall), .arch_data_o(arch_data),
    .spec_data_o(spec_data), .spec_valid_o(spec_valid)
  );
  always #5 clk = ~clk;

  // Reference: ordered list of in-flight writers, oldest first
  task automatic model_step(bit a, bit wv, int wt, logic [63:0] wd, bit c, bit f);
    bit full = mq.size() == D;
    bit retire = mq.size() > 0 && c && (mq[0].wr || (wv && wt == mq[0].tag));
    if (retire) march = mq[0].wr ? mq[0].d : wd;
    if (f) begin
      mq.delete();
      mnext = 0;
      return;
    end
    if (wv) foreach (mq[i]) if (mq[i].tag == wt) begin mq[i].wr = 1; mq[i].d = wd; end
    if (retire) void'(mq.pop_front());
    if (a && !full) begin
      mq.push_back('{mnext, 1'b0, 64'h0});
      mnext = (mnext + 1) % D;
    end
  endtask

  task automatic step(bit a, bit wv, int wt, logic [63:0] wd, bit c, bit f);
    alloc = a; wr_valid = wv; wr_tag = 2'(wt); wr_data = wd; commit = c; flush = f;
    model_step(a, wv, wt, wd, c, f);
    @(posedge clk); #1;
    alloc = 0; wr_valid = 0; commit = 0; flush = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mq.delete(); mnext = 0; march = 0;
    total++; if (arch_data !== 64'h0) $display("FAIL reset_arch got %h want 0", arch_data); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    total++; if (alloc_tag !== 2'd0) $display("FAIL reset_tag got %0d want 0", alloc_tag); else passed++;
    total++; if (spec_valid !== 1'b1) $display("FAIL reset_spec_valid got %b want 1", spec_valid); else passed++;
    total++; if (commit_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", commit_stall); else passed++;
  endtask

  task automatic test_fill_retire;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    total++; if (alloc_tag !== 2'd2) $display("FAIL fill_tag got %0d want 2", alloc_tag); else passed++;
    step(0, 1, 1, 64'hAAAA, 0, 0);
    step(0, 1, 0, 64'h5555, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    total++; if (arch_data !== 64'h5555) $display("FAIL retire0 got %h want 5555", arch_data); else passed++;
    total++; if (spec_valid !== FWD) $display("FAIL retire0_spec_valid got %b want %b", spec_valid, FWD); else passed++;
    step(0, 0, 0, 0, 1, 0);
    total++; if (arch_data !== 64'hAAAA) $display("FAIL retire1 got %h want aaaa", arch_data); else passed++;
    total++; if (spec_valid !== 1'b1 || ready !== 1'b1) $display("FAIL retire1_empty got sv=%b rdy=%b want 1 1", spec_valid, ready); else passed++;
  endtask

  task automatic test_full_stall;
    step(0, 0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    total++; if (ready !== 1'b0) $display("FAIL full_ready got %b want 0", ready); else passed++;
    step(1, 0, 0, 0, 0, 0);
    total++; if (alloc_tag !== 2'd0) $display("FAIL full_tag got %0d want 0", alloc_tag); else passed++;
    total++; if (commit_stall !== 1'b1) $display("FAIL full_stall got %b want 1", commit_stall); else passed++;
    step(0, 0, 0, 0, 1, 0);
    total++; if (arch_data !== 64'hAAAA) $display("FAIL stall_arch got %h want aaaa", arch_data); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL stall_ready got %b want 0", ready); else passed++;
  endtask

  task automatic test_bypass;
    step(0, 1, 0, 64'h1234, 1, 0);
    total++; if (arch_data !== 64'h1234) $display("FAIL bypass_arch got %h want 1234", arch_data); else passed++;
    total++; if (ready !== 1'b1 || commit_stall !== 1'b1) $display("FAIL bypass_state got rdy=%b stall=%b want 1 1", ready, commit_stall); else passed++;
  endtask

  task automatic test_flush;
    step(0, 1, 1, 64'hBEEF, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    total++; if (arch_data !== 64'hBEEF) $display("FAIL flush_arch got %h want beef", arch_data); else passed++;
    total++; if (ready !== 1'b1 || alloc_tag !== 2'd0 || commit_stall !== 1'b0) $display("FAIL flush_state got rdy=%b tag=%0d stall=%b want 1 0 0", ready, alloc_tag, commit_stall); else passed++;
    step(0, 1, 1, 64'h99, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 64'h11, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    total++; if (arch_data !== 64'h11) $display("FAIL post_flush_arch got %h want 11", arch_data); else passed++;
    total++; if (commit_stall !== 1'b1) $display("FAIL stale_write got stall=%b want 1", commit_stall); else passed++;
    step(0, 0, 0, 0, 1, 0);
    total++; if (arch_data !== 64'h11) $display("FAIL stale_commit got %h want 11", arch_data); else passed++;
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_spec;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 64'h77, 0, 0);
    total++; if (spec_valid !== FWD) $display("FAIL spec_w0_valid got %b want %b", spec_valid, FWD); else passed++;
    if (FWD) begin
      total++; if (spec_data !== 64'h77) $display("FAIL spec_w0_data got %h want 77", spec_data); else passed++;
    end
    step(1, 0, 0, 0, 0, 0);
    total++; if (spec_valid !== 1'b0) $display("FAIL spec_a1_valid got %b want 0", spec_valid); else passed++;
    step(0, 1, 1, 64'h88, 0, 0);
    total++; if (spec_valid !== FWD) $display("FAIL spec_w1_valid got %b want %b", spec_valid, FWD); else passed++;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    total++; if (spec_valid !== 1'b1 || spec_data !== 64'h88) $display("FAIL spec_retired got sv=%b d=%h want 1 88", spec_valid, spec_data); else passed++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      bit e_ready = mq.size() != D;
      bit e_stall = mq.size() > 0 && !mq[0].wr;
      bit e_sv = FWD ? (mq.size() == 0 || mq[$].wr) : (mq.size() == 0);
      logic [63:0] e_sd = (FWD && mq.size() > 0) ? mq[$].d : march;
      int wt = $urandom_range(D - 1);
      total++; if (ready !== e_ready || alloc_tag !== 2'(mnext) || commit_stall !== e_stall)
        $display("FAIL rnd_ctrl[%0d] got rdy=%b tag=%0d stall=%b want %b %0d %b", n, ready, alloc_tag, commit_stall, e_ready, mnext, e_stall);
      else passed++;
      total++; if (arch_data !== march || spec_valid !== e_sv || (e_sv && spec_data !== e_sd))
        $display("FAIL rnd_data[%0d] got a=%h sv=%b sd=%h want %h %b %h", n, arch_data, spec_valid, spec_data, march, e_sv, e_sd);
      else passed++;
      if (n % 8 == 0 && mq.size() > 0) wt = mq[0].tag;
      step($urandom_range(99) < 55, $urandom_range(99) < 50, wt, {$urandom, $urandom},
           $urandom_range(99) < 45, $urandom_range(99) < 4);
    end
  endtask

  initial begin
    test_reset();
    test_fill_retire();
    test_full_stall();
    test_bypass();
    test_flush();
    test_spec();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
